// File: rtl/d_sram_to_sram_like_pkg.sv
// Shared types for the sram-to-sram-like bridges: FSM states, transfer sizes, address map.
// Optional build macro: DMEM_ADDR_MAP_EN (MIPS kseg0/kseg1 fixed mapping on the bus address).
package d_sram_to_sram_like_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic [31:0] map_addr(input logic [31:0] addr);
`ifdef DMEM_ADDR_MAP_EN
        // kseg0/kseg1 alias onto the low 512 MB of physical space
        return (addr[31:30] == 2'b10) ? {3'b000, addr[28:0]} : addr;
`else
        return addr;
`endif
    endfunction

endpackage

// File: rtl/wen_to_size.sv
// Byte-write mask to sram-like transfer size decoder; shared by the data and instruction bridges.
module wen_to_size
    import d_sram_to_sram_like_pkg::*;
(
    input  logic [3:0] wen,
    output logic [1:0] size
);

    always_comb begin
        size = SIZE_WORD;
        case (wen)
            4'b0011, 4'b1100:                   size = SIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
            default:                            size = SIZE_WORD;
        endcase
    end

endmodule

// File: rtl/d_sram_to_sram_like.sv
// Data-side bridge: stall-based core data port to sram-like request/response bus.
// Optional build macro: DMEM_ADDR_MAP_EN (address mapping applied to data_addr).
module d_sram_to_sram_like
    import d_sram_to_sram_like_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        d_stall,
    input  logic        longest_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    state_t      state, state_next;
    logic        req_raw;
    logic        capture;
    logic [1:0]  size_raw;
    logic        is_read;

    assign is_read = ~|data_sram_wen;

    wen_to_size u_wen_to_size (
        .wen  (data_sram_wen),
        .size (size_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            data_sram_rdata <= '0;
        end else begin
            state <= state_next;
            if (capture) data_sram_rdata <= data_rdata;
        end
    end

    always_comb begin
        state_next = state;
        req_raw    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE, ADDR: begin
                // dropping the strobe in ADDR withdraws the request (pipeline flush)
                if (!data_sram_en) begin
                    state_next = IDLE;
                end else begin
                    req_raw = 1'b1;
                    if (data_addr_ok && data_data_ok) begin
                        state_next = HOLD;
                        capture    = is_read;
                    end else if (data_addr_ok) begin
                        state_next = DATA;
                    end else begin
                        state_next = ADDR;
                    end
                end
            end
            DATA: begin
                if (data_data_ok) begin
                    state_next = HOLD;
                    capture    = is_read;
                end
            end
            HOLD: begin
                if (!longest_stall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is asserted so the bus sees an idle port at once
    assign data_req   = req_raw & ~rst;
    assign d_stall    = data_sram_en & (state != HOLD) & ~rst;
    assign data_wr    = (|data_sram_wen) & ~rst;
    assign data_size  = rst ? '0 : size_raw;
    assign data_addr  = rst ? '0 : map_addr(data_sram_addr);
    assign data_wdata = rst ? '0 : data_sram_wdata;

endmodule

// File: tb/tb_d_sram_to_sram_like.sv
// Directed scoreboard bench for d_sram_to_sram_like; honours DMEM_ADDR_MAP_EN for address expectations.
module tb_d_sram_to_sram_like;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_q[$];
    logic [31:0] hold_val;
    int req_cnt, stall_cnt;

    always #5 clk = ~clk;

    d_sram_to_sram_like dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .d_stall         (d_stall),
        .longest_stall   (longest_stall),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed %h expected <scoreboard empty>", tag, data_sram_rdata);
        end else begin
            exp = sb_q.pop_front();
            check(tag, data_sram_rdata, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] wen_tab  [8] = '{4'b0001, 4'b0100, 4'b0011, 4'b1111, 4'b0101, 4'b1100, 4'b0000, 4'b1000};
    logic [1:0] size_tab [8] = '{2'd0,    2'd0,    2'd1,    2'd2,    2'd2,    2'd1,    2'd2,    2'd0};

    localparam logic [31:0] EXP_ADDR_K0 =
`ifdef DMEM_ADDR_MAP_EN
        32'h0000_0010;
`else
        32'h8000_0010;
`endif
    localparam logic [31:0] EXP_ADDR_K1 =
`ifdef DMEM_ADDR_MAP_EN
        32'h0000_1000;
`else
        32'hA000_1000;
`endif

    initial begin
        rst = 1'b1;
        data_sram_en = 1'b0; data_sram_wen = '0; data_sram_addr = '0; data_sram_wdata = '0;
        longest_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        #3;
        check("rst_req",   {31'd0, data_req}, 32'd0);
        check("rst_stall", {31'd0, d_stall},  32'd0);
        check("rst_rdata", data_sram_rdata,   32'd0);
        check("rst_size",  {30'd0, data_size}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Read, zero wait
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h8000_0010;
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; longest_stall = 1'b1;
        sb_q.push_back(32'hDEAD_BEEF);
        #1;
        check("rd0_req",   {31'd0, data_req},  32'd1);
        check("rd0_stall", {31'd0, d_stall},   32'd1);
        check("rd0_size",  {30'd0, data_size}, 32'd2);
        check("rd0_wr",    {31'd0, data_wr},   32'd0);
        check("rd0_addr",  data_addr, EXP_ADDR_K0);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        check("rd0_req_c1",   {31'd0, data_req}, 32'd0);
        check("rd0_stall_c1", {31'd0, d_stall},  32'd0);
        check_pop("rd0_rdata");
        longest_stall = 1'b0; data_sram_en = 1'b0;
        tick();
        #1;
        check("rd0_idle_stall", {31'd0, d_stall}, 32'd0);

        // Write, delayed handshake: addr_ok in cycle 3, data_ok in cycle 5
        data_sram_en = 1'b1; data_sram_wen = 4'b1100; data_sram_wdata = 32'h1234_0000;
        data_sram_addr = 32'h0000_0100; longest_stall = 1'b1;
        sb_q.push_back(32'hDEAD_BEEF);
        req_cnt = 0; stall_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            data_addr_ok = (c == 3);
            data_data_ok = (c == 5);
            data_rdata   = 32'hFFFF_0000 | c;
            #1;
            req_cnt   += int'(data_req);
            stall_cnt += int'(d_stall);
            if (c == 0) begin
                check("wr_wr",    {31'd0, data_wr},   32'd1);
                check("wr_size",  {30'd0, data_size}, 32'd1);
                check("wr_wdata", data_wdata, 32'h1234_0000);
            end
            if (c == 6) begin
                check("wr_req_cycles",   req_cnt,   32'd4);
                check("wr_stall_cycles", stall_cnt, 32'd6);
                check_pop("wr_rdata_kept");
                longest_stall = 1'b0; data_sram_en = 1'b0;
            end
            tick();
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0;

        // Hold under external stall
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0000_0200;
        longest_stall = 1'b1; data_addr_ok = 1'b1;
        #1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        hold_val = 32'hCAFE_F00D;
        #1;
        check("hold_dok_stall", {31'd0, d_stall}, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            data_rdata   = $urandom;
            data_data_ok = i[0];
            data_addr_ok = ~i[0];
            #1;
            check("hold_no_req", {31'd0, data_req}, 32'd0);
            check("hold_rdata",  data_sram_rdata, hold_val);
            tick();
        end
        longest_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        check("hold_exit_req", {31'd0, data_req}, 32'd0);
        tick();
        #1;
        check("idle_again_req",   {31'd0, data_req}, 32'd1);
        check("idle_again_stall", {31'd0, d_stall},  32'd1);
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D; longest_stall = 1'b1;
        sb_q.push_back(32'h0BAD_F00D);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        check_pop("rd2_rdata");
        data_sram_en = 1'b0; longest_stall = 1'b0;
        tick();

        // Size decode
        for (int i = 0; i < 8; i++) begin
            data_sram_wen = wen_tab[i];
            #1;
            check("size_decode", {30'd0, data_size}, {30'd0, size_tab[i]});
        end
        data_sram_wen = 4'b0000;

        // Flush in ADDR, then a stray data_ok in IDLE
        data_sram_en = 1'b1; data_sram_addr = 32'h0000_0300; longest_stall = 1'b1;
        #1;
        tick();
        #1;
        check("flush_addr_req", {31'd0, data_req}, 32'd1);
        data_sram_en = 1'b0;
        #1;
        check("flush_withdrawn", {31'd0, data_req}, 32'd0);
        tick();
        data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
        #1;
        check("stray_req",   {31'd0, data_req}, 32'd0);
        check("stray_stall", {31'd0, d_stall},  32'd0);
        tick();
        data_data_ok = 1'b0;
        #1;
        check("stray_rdata", data_sram_rdata, 32'h0BAD_F00D);
        data_sram_en = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h55AA_55AA;
        sb_q.push_back(32'h55AA_55AA);
        #1;
        check("post_flush_req", {31'd0, data_req}, 32'd1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        check_pop("post_flush_rdata");
        data_sram_en = 1'b0; longest_stall = 1'b0;
        tick();

        // Async reset mid-DATA, then address map
        data_sram_en = 1'b1; data_sram_wen = 4'b1111; data_sram_wdata = 32'h1111_2222;
        data_sram_addr = 32'hA000_1000; data_addr_ok = 1'b1; longest_stall = 1'b1;
        #1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        check("data_state_stall", {31'd0, d_stall},  32'd1);
        check("data_state_req",   {31'd0, data_req}, 32'd0);
        rst = 1'b1;
        #1;
        check("arst_stall", {31'd0, d_stall},   32'd0);
        check("arst_req",   {31'd0, data_req},  32'd0);
        check("arst_wr",    {31'd0, data_wr},   32'd0);
        check("arst_size",  {30'd0, data_size}, 32'd0);
        check("arst_addr",  data_addr,  32'd0);
        check("arst_wdata", data_wdata, 32'd0);
        check("arst_rdata", data_sram_rdata, 32'd0);
        tick();
        rst = 1'b0; data_sram_wen = 4'b0000; longest_stall = 1'b0;
        #1;
        check("map_k1_addr", data_addr, EXP_ADDR_K1);
        check("post_rst_req", {31'd0, data_req}, 32'd1);
        data_sram_addr = 32'h4000_0020;
        #1;
        check("map_kuseg_addr", data_addr, 32'h4000_0020);
        data_sram_en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/d_sram_to_sram_like.md
# d_sram_to_sram_like

Data-side bridge between the MIPS core's stall-based data-memory port and the SoC's sram-like request/response bus. It takes the core's memory-stage strobe, byte-write mask, address and write data. It issues one sram-like transaction per access and raises a data stall until the response arrives. It then holds the read data steady until the whole pipeline releases its stall. It sits directly downstream of the core's data port and upstream of the sram-like-to-AXI converter.

## Interface
Parameters:
- none. Widths are fixed: 32-bit address and data, 4-bit write mask.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- data_sram_en  in  1  core access strobe (mem_enM)
- data_sram_wen  in  4  byte write mask; 0000 means read
- data_sram_addr  in  32  byte address (aluoutM)
- data_sram_wdata  in  32  write data, already lane-aligned
- data_sram_rdata  out  32  read data returned to core; reset 0
- d_stall  out  1  data stall to core; reset 0
- longest_stall  in  1  global pipeline stall from core
- data_req  out  1  sram-like request; reset 0
- data_wr  out  1  1 = write; reset 0
- data_size  out  2  0 = byte, 1 = half, 2 = word; reset 0
- data_addr  out  32  transaction address; reset 0
- data_wdata  out  32  write data; reset 0
- data_addr_ok  in  1  slave accepted the address
- data_data_ok  in  1  slave completed; read data valid
- data_rdata  in  32  slave read data

## Operation
- The FSM has four states: IDLE, ADDR, DATA and HOLD. Reset sends the FSM to IDLE.
- **IDLE:**
  - If data_sram_en=1, assert data_req combinationally and go to ADDR. If data_addr_ok=1 in the same cycle, skip ADDR and go to DATA.
  - If data_addr_ok and data_data_ok both arrive in that cycle, go to HOLD.
- **ADDR:**
  - data_req=1.
  - On data_addr_ok, go to DATA, or to HOLD if data_data_ok is also high.
- **DATA:**
  - data_req=0.
  - On data_data_ok, capture data_rdata into data_sram_rdata (reads only; writes leave it unchanged) and go to HOLD.
- **HOLD:**
  - data_req=0 and d_stall=0.
  - When longest_stall=0, go to IDLE.
  - data_sram_rdata stays constant for the whole time the FSM is in HOLD.
- **Stall:** d_stall = data_sram_en & (state != HOLD). It stays high during the data_data_ok cycle.
- **data_wr:** data_wr = |data_sram_wen.
- **data_size, derived from data_sram_wen:**
  - 0000 or 1111 → 2
  - 0011 or 1100 → 1
  - single-hot → 0
  - any other pattern → 2
- **Drive-through:** data_addr and data_wdata follow the core inputs. The core holds them stable while stalled, so the bridge does not register them.
- **Stray responses:** data_data_ok in IDLE or ADDR (without addr_ok) is ignored. So is data_addr_ok outside IDLE or ADDR.
- **Dropped strobe:** if data_sram_en drops while in ADDR (flush), the request is withdrawn and the FSM returns to IDLE. Once addr_ok has been seen, the FSM always waits for data_ok.
- **Reset mid-transaction:** the FSM returns to IDLE. The slave is reset by the same rst, so no response is pending afterwards.

## Timing
- Minimum latency with addr_ok and data_ok both high in the request cycle is one cycle:
  - d_stall is high in cycle 0.
  - Read data is valid and d_stall is low in cycle 1.
- Exactly one transaction is outstanding at any time. data_req never reasserts before the prior data_ok.
- A new access can be requested no earlier than the cycle after HOLD exits.

## Configuration
- With DMEM_ADDR_MAP_EN defined, data_addr applies MIPS fixed mapping:
  - kseg0/kseg1 (addr[31:30]=2'b10) clear bits [31:29].
  - All other addresses pass unchanged.
- Without DMEM_ADDR_MAP_EN, data_addr equals data_sram_addr exactly.

## Structure
- The shared package holds:
  - the FSM state encoding: IDLE=0, ADDR=1, DATA=2, HOLD=3
  - the size constants SIZE_BYTE, SIZE_HALF, SIZE_WORD
- One sub-module, wen_to_size, is the combinational mask-to-size decoder. The future instruction-side bridge reuses it.

## Test plan
- **Read, zero wait:**
  - Stimulus: en=1, wen=0000, addr=0x8000_0010; slave gives addr_ok and data_ok in the same cycle with rdata=0xDEAD_BEEF.
  - Required: req high for 1 cycle, size=2; d_stall drops the next cycle with rdata=0xDEAD_BEEF.
- **Write, delayed handshake:**
  - Stimulus: wen=1100, wdata=0x1234_0000; addr_ok after 3 cycles, data_ok after 2 more.
  - Required: wr=1 and size=1; req held for exactly 4 cycles; d_stall high for 6 cycles.
- **Hold under external stall:**
  - Stimulus: longest_stall held high for 5 cycles after data_ok.
  - Required: rdata constant; no second req; return to IDLE in the cycle after longest_stall falls.
- **Size decode:**
  - Stimulus: wen = 0001, 0100, 0011, 1111, 0101.
  - Required: size = 0, 0, 1, 2, 2.
- **Flush and spurious responses:**
  - Stimulus: en drops while in ADDR; data_ok pulsed while in IDLE.
  - Required: req withdrawn, FSM returns to IDLE, and data_ok changes nothing.
- **Async reset mid-transaction and address map:**
  - Stimulus: rst asserted mid-DATA; addr=0xA000_1000 with DMEM_ADDR_MAP_EN defined.
  - Required: reset clears all outputs immediately, without waiting for clk; data_addr=0x0000_1000.
